// File: rtl/qupls_rf_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// qupls_rf_read_arbiter_if
// Groups the operand-read requester bus and the register-file read-port bus
// of the register-file read arbiter.
//
//   req_i      [NREQ]           per-requester read request, held until granted
//   regno_i    [NREQ][7]        architectural register (regx + 6b) per requester
//   gnt_o      [NREQ]           one-cycle grant pulse
//   rf_stall_i                  register file unavailable this cycle
//   rf_ra_o    [NPORT][7]       read address per register-file port
//   rf_rd_i    [NPORT][DW]      read data, one cycle after the address
//   rdata_o    [NREQ][DW]       returned operand per requester
//   rvalid_o   [NREQ]           rdata_o valid pulse
//
// Modports: master = requester/register-file side, slave = arbiter.
// ---------------------------------------------------------------------------
interface qupls_rf_read_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NPORT = 2,
  parameter int DW    = 64
);
  logic [NREQ-1:0]           req_i;
  logic [NREQ-1:0][6:0]      regno_i;
  logic [NREQ-1:0]           gnt_o;
  logic                      rf_stall_i;
  logic [NPORT-1:0][6:0]     rf_ra_o;
  logic [NPORT-1:0][DW-1:0]  rf_rd_i;
  logic [NREQ-1:0][DW-1:0]   rdata_o;
  logic [NREQ-1:0]           rvalid_o;

  modport master (
    output req_i, regno_i, rf_stall_i, rf_rd_i,
    input  gnt_o, rf_ra_o, rdata_o, rvalid_o
  );

  modport slave (
    input  req_i, regno_i, rf_stall_i, rf_rd_i,
    output gnt_o, rf_ra_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/qupls_rf_read_arbiter.sv
// ---------------------------------------------------------------------------
// qupls_rf_read_arbiter
// Shares NPORT register-file read ports among NREQ operand-read requesters.
// Each cycle the requesters are scanned round-robin starting at pointer rr;
// the k-th granted nonzero register takes port k. Register 0 is granted
// without a port and returns zero. Data comes back exactly one cycle after
// the grant through a registered grant-to-port map.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   qupls_rf_read_arbiter_if.slave (request, grant, RF port, return)
//
// Configuration macro:
//   QUPLS_RFARB_DEDUP_EN  when defined, requesters naming the same nonzero
//                         register in one cycle share a single port.
// ---------------------------------------------------------------------------
module qupls_rf_read_arbiter #(
  parameter int NREQ  = 4,
  parameter int NPORT = 2,
  parameter int DW    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  qupls_rf_read_arbiter_if.slave       bus
);

  localparam int RW = (NREQ  > 1) ? $clog2(NREQ)  : 1;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [RW-1:0]             rr_r;
  logic [RW-1:0]             rr_nxt_s;
  logic [NREQ-1:0]           gnt_s;
  logic [NREQ-1:0]           zero_s;
  logic [NREQ-1:0][PW-1:0]   port_of_s;
  logic [NPORT-1:0][6:0]     ra_s;

  logic [NREQ-1:0]           pend_valid_r;
  logic [NREQ-1:0]           pend_zero_r;
  logic [NREQ-1:0][PW-1:0]   pend_port_r;
  logic [NREQ-1:0][DW-1:0]   hold_r;
  logic [NREQ-1:0][DW-1:0]   ret_s;
  logic [NREQ-1:0][DW-1:0]   rdata_s;

  int                        idx_s;
  int                        used_s;
  logic                      hit_s;

  // Round-robin scan: grant requests, allocate ports, compute next rr.
  always_comb begin
    gnt_s     = '0;
    zero_s    = '0;
    port_of_s = '0;
    ra_s      = '0;
    rr_nxt_s  = rr_r;
    idx_s     = 0;
    used_s    = 0;
    hit_s     = 1'b0;
    if (!rst && !bus.rf_stall_i) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = (int'(rr_r) + k) % NREQ;
        hit_s = 1'b0;
        if (bus.req_i[idx_s]) begin
          if (bus.regno_i[idx_s] == 7'd0) begin
            // Register 0 reads as zero and never needs a port.
            gnt_s[idx_s]  = 1'b1;
            zero_s[idx_s] = 1'b1;
          end else begin
`ifdef QUPLS_RFARB_DEDUP_EN
            // Piggy-back on a port already reading the same register;
            // such a grant does not move rr.
            for (int p = 0; p < NPORT; p++) begin
              if (!hit_s && (p < used_s) && (ra_s[p] == bus.regno_i[idx_s])) begin
                hit_s            = 1'b1;
                gnt_s[idx_s]     = 1'b1;
                port_of_s[idx_s] = PW'(p);
              end else begin
                hit_s = hit_s;
              end
            end
`endif
            if (!hit_s && (used_s < NPORT)) begin
              ra_s[used_s]     = bus.regno_i[idx_s];
              port_of_s[idx_s] = PW'(used_s);
              gnt_s[idx_s]     = 1'b1;
              rr_nxt_s         = RW'((idx_s + 1) % NREQ);
              used_s           = used_s + 1;
            end else begin
              used_s = used_s;
            end
          end
        end else begin
          hit_s = 1'b0;
        end
      end
    end else begin
      rr_nxt_s = rr_r;
    end
  end

  // Select the returned operand from the port captured at grant time.
  always_comb begin
    ret_s   = '0;
    rdata_s = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (pend_zero_r[n]) begin
        ret_s[n] = '0;
      end else begin
        ret_s[n] = bus.rf_rd_i[pend_port_r[n]];
      end
      // Outside a return pulse the last delivered operand is held.
      if (pend_valid_r[n]) begin
        rdata_s[n] = ret_s[n];
      end else begin
        rdata_s[n] = hold_r[n];
      end
    end
  end

  // Pointer, pending grant map and held return data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r         <= '0;
      pend_valid_r <= '0;
      pend_zero_r  <= '0;
      pend_port_r  <= '0;
      hold_r       <= '0;
    end else begin
      rr_r         <= rr_nxt_s;
      pend_valid_r <= gnt_s;
      pend_zero_r  <= zero_s;
      pend_port_r  <= port_of_s;
      for (int n = 0; n < NREQ; n++) begin
        if (pend_valid_r[n]) begin
          hold_r[n] <= ret_s[n];
        end else begin
          hold_r[n] <= hold_r[n];
        end
      end
    end
  end

  assign bus.gnt_o    = gnt_s;
  assign bus.rf_ra_o  = ra_s;
  assign bus.rvalid_o = pend_valid_r;
  assign bus.rdata_o  = rdata_s;

endmodule

// File: doc/qupls_rf_read_arbiter.md
QUPLS_RF_READ_ARBITER -- requirements
Module: Qupls_rf_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of operand-read requesters (decoded Ra/Rb/Rc sources).
REQ-002 SHALL have parameter NPORT, default 2: number of register-file read ports shared by requesters.
REQ-003 SHALL have parameter DW, default 64: register data width.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port clk  input  1: the single clock; all state on rising edge.
REQ-006 SHALL have port req_i  input  NREQ: per-requester read request, held until granted.
REQ-007 SHALL have port regno_i  input  NREQ x aregno_t (7b: regx + 6b): architectural register per requester.
REQ-008 SHALL have port gnt_o  output  NREQ: one-cycle grant pulse, combinational from current state and inputs.
REQ-009 SHALL have port rf_stall_i  input  1: register file unavailable; no grants this cycle.
REQ-010 SHALL have port rf_ra_o  output  NPORT x aregno_t: read address per port.
REQ-011 SHALL have port rf_rd_i  input  NPORT x DW: read data, valid one cycle after address.
REQ-012 SHALL have port rdata_o  output  NREQ x DW: returned operand per requester.
REQ-013 SHALL have port rvalid_o  output  NREQ: rdata_o[n] valid, one-cycle pulse.

Function
REQ-014 SHALL grant per cycle at most NPORT requesters whose regno is nonzero, scanning req_i from round-robin pointer rr upward modulo NREQ.
REQ-015 SHALL grant a request with regno 0 immediately, without consuming a port; data returned is 0.
REQ-016 SHALL assign the k-th granted nonzero request to port k; unused ports drive rf_ra_o = 0.
REQ-017 SHALL, when rf_stall_i=1, assert no grants (including regno 0), leave rr unchanged, and issue no new reads.
REQ-018 SHALL advance rr to (index of last port-consuming grant + 1) mod NREQ; rr unchanged when no port-consuming grant occurs.
REQ-019 SHALL register grant-to-port mapping; one cycle after gnt_o[n], drive rvalid_o[n]=1 and rdata_o[n] from mapped port's rf_rd_i (or 0 for regno 0).
REQ-020 SHALL have fixed latency of 1 cycle from gnt_o to rvalid_o, independent of rf_stall_i in the return cycle.
REQ-021 SHALL hold rdata_o[n] at its last value when rvalid_o[n]=0.
REQ-022 SHALL never grant a requester twice for one request; a deasserted req_i at grant time produces no grant.
REQ-023 SHALL guarantee starvation freedom: any held request granted within ceil(NREQ/NPORT) non-stalled cycles.

Reset
REQ-024 SHALL, on rst assertion, asynchronously clear rr to 0, rvalid_o to 0, rdata_o to 0, and pending mapping; in-flight reads discarded.
REQ-025 SHALL produce no grants while rst is high; first grant possible on first clk edge after rst deasserts.

Configuration
REQ-026 SHALL support macro QUPLS_RFARB_DEDUP_EN.
REQ-027 With QUPLS_RFARB_DEDUP_EN defined: requesters with identical nonzero regno in a cycle share one port; all granted together, all receive same data; only the first counts toward rr advance.
REQ-028 Without QUPLS_RFARB_DEDUP_EN: every nonzero request consumes its own port, duplicates included.

Verification
REQ-029 After reset, req_i=4'b1111, regno={5,6,7,8}, no stall -> cycle0 gnt_o=4'b0011, ra={5,6}; cycle1 gnt_o=4'b1100, rvalid_o=4'b0011 with RF data; cycle2 rvalid_o=4'b1100.
REQ-030 req_i=4'b0101, regno[0]=0, regno[2]=9 -> gnt_o=4'b0101, port0 addr 9, port1 addr 0; next cycle rdata_o[0]=0, rdata_o[2]=RF[9].
REQ-031 rf_stall_i=1 for 3 cycles with req_i=4'b1111 -> gnt_o=0, rr unchanged; stall release -> grants resume at same rr.
REQ-032 rst asserted the cycle after a grant -> rvalid_o stays 0, rr=0 after release.
REQ-033 DEDUP_EN defined, regno={3,3,3,4}, req_i=4'b1111 -> gnt_o=4'b1111 in one cycle, ports {3,4}; without macro -> gnt_o=4'b0011 then 4'b1100.
REQ-034 Continuous req_i=4'b1111 for 8 cycles -> each requester granted exactly 4 times, max grant gap 2 cycles.
